upravljac_mreze: RTL and testbench
==================================

# upravljac_mreze

Sequencing controller for the mine-detection network. It loads a 60-feature sample as serial 16-bit words over a valid/ready stream and assembles the 960-bit `uzorak` vector that drives the combinational network. It then waits a fixed settle time, captures the two output scores and their sign indicators, and offers them downstream over a second valid/ready handshake. It sits between the sample source (sensor/UART front end) and the network instance, and it is the only block that writes the network input.

## Interface
- `N_ZNACAJKI`, 60: features per sample; `uzorak` width is 16·`N_ZNACAJKI`.
- `SMIRIVANJE`, 4: settle cycles between the last accepted word and result capture; legal range ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ulaz_valid` in 1: input word valid.
- `ulaz_ready` out 1: controller accepts a word.
- `ulaz_podatak` in 16: feature word, two's complement.
- `ulaz_zadnji` in 1: marks the last word of a sample.
- `uzorak` out 960: network input vector.
- `mreza_izlaz_1`, `mreza_izlaz_2` in 16: network scores.
- `mreza_ind_1`, `mreza_ind_2` in 1: network sign indicators.
- `rez_valid` out 1: result available.
- `rez_ready` in 1: consumer takes the result.
- `rez_izlaz_1`, `rez_izlaz_2` out 16: captured scores.
- `rez_ind_1`, `rez_ind_2` out 1: captured indicators.
- `greska` out 1: sticky framing error.
- `broj_uzoraka` out 16: completed-result count.

## Operation
- States: PUNJENJE (load), ODBACIVANJE (discard), SMIRIVANJE (settle), IZLAZ (present). Reset state is PUNJENJE.
- A word is accepted on a rising edge with `ulaz_valid && ulaz_ready`.
- `ulaz_ready` = 1 in PUNJENJE and ODBACIVANJE, and 0 otherwise. It is decoded from state only and never depends on `ulaz_valid`.
- PUNJENJE:
  - Accepted word k (k = 0..59, held in a 6-bit index) is written to `uzorak[16k+15:16k]`. Other slices are unchanged.
  - `ulaz_zadnji` on k = 59: go to SMIRIVANJE; index ← 0.
  - `ulaz_zadnji` on k < 59: set `greska`, index ← 0, stay in PUNJENJE. Slices already written remain, and the next sample overwrites them.
  - k = 59 accepted without `ulaz_zadnji`: set `greska`, go to ODBACIVANJE.
- ODBACIVANJE: accept and drop words, leaving `uzorak` unchanged. An accepted word with `ulaz_zadnji` returns the block to PUNJENJE with index 0.
- SMIRIVANJE: a counter runs 0..`SMIRIVANJE`−1. On the edge where it equals `SMIRIVANJE`−1:
  - `rez_*` ← the four network inputs;
  - go to IZLAZ.
- IZLAZ: `rez_valid` = 1. On an edge with `rez_ready` = 1, go to PUNJENJE and increment `broj_uzoraka`. `rez_*` hold their values until the next capture.
- `uzorak` changes only on accepted PUNJENJE words, so it is stable through SMIRIVANJE and IZLAZ.
- `greska` is cleared only by `rst`.
- `broj_uzoraka` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: state PUNJENJE, index 0, `ulaz_ready` 1, `uzorak` 0, `rez_valid` 0, `rez_izlaz_*` 0, `rez_ind_*` 0, `greska` 0, `broj_uzoraka` 0.
- Throughput is one word per cycle while `ulaz_valid` stays high.
- Last word accepted at edge T: `ulaz_ready` = 0 from T, capture happens at edge T+`SMIRIVANJE`, and `rez_valid` = 1 from that edge.
- Result handshake at edge H: `rez_valid` = 0 and `ulaz_ready` = 1 from H. The earliest next-word accept is edge H+1.
- Minimum sample period is 60 + `SMIRIVANJE` + 1 cycles.
- `rst` asserted in any state clears everything immediately, without waiting for a clock, and any partial sample is lost.
- `ulaz_valid` held high while `ulaz_ready` = 0 has no effect.
- In IZLAZ, `rez_ready` low stalls indefinitely with outputs stable.

## Configuration
- `UPRAVLJAC_BROJAC_EN` defined: the `broj_uzoraka` counter is built as described above.
- `UPRAVLJAC_BROJAC_EN` undefined: no counter register is built, and `broj_uzoraka` is constant 0. All other behaviour is identical.

## Test plan
- Reset, then 60 words of value k with `ulaz_zadnji` on word 59, network stub returning 0x8001/0x0002:
  - after 4 cycles `rez_valid` = 1, `rez_izlaz_1` = 0x8001, `rez_ind_1` = 1, `rez_ind_2` = 0;
  - `uzorak[16k+15:16k]` = k.
- Same sample with `rez_ready` held low 10 cycles:
  - `rez_*` stable and `ulaz_ready` = 0 throughout;
  - `rez_ready` pulse gives `broj_uzoraka` = 1 and `ulaz_ready` = 1 next cycle.
- `ulaz_zadnji` on word 10:
  - `greska` = 1, no `rez_valid`;
  - a following correct 60-word sample completes normally.
- 65 words with `ulaz_zadnji` only on word 64:
  - `greska` = 1, words 60–64 dropped, no result;
  - next sample accepted from index 0.
- `rst` pulsed mid-SMIRIVANJE: all outputs return to reset values asynchronously, and no result is produced.
- With `UPRAVLJAC_BROJAC_EN`, preload 0xFFFF completions by force, then complete one sample: `broj_uzoraka` = 0x0000. Without the macro it stays at 0.

Source files
------------

// File: rtl/upravljac_mreze.sv
// Sequencing controller: loads a serial 60-word sample into the network input,
// waits SMIRIVANJE cycles, captures scores. Optional counter: UPRAVLJAC_BROJAC_EN.
module upravljac_mreze #(
    parameter int N_ZNACAJKI = 60,
    parameter int SMIRIVANJE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ulaz_valid,
    output logic                    ulaz_ready,
    input  logic [15:0]             ulaz_podatak,
    input  logic                    ulaz_zadnji,
    output logic [16*N_ZNACAJKI-1:0] uzorak,
    input  logic [15:0]             mreza_izlaz_1,
    input  logic [15:0]             mreza_izlaz_2,
    input  logic                    mreza_ind_1,
    input  logic                    mreza_ind_2,
    output logic                    rez_valid,
    input  logic                    rez_ready,
    output logic [15:0]             rez_izlaz_1,
    output logic [15:0]             rez_izlaz_2,
    output logic                    rez_ind_1,
    output logic                    rez_ind_2,
    output logic                    greska,
    output logic [15:0]             broj_uzoraka
);
    localparam int IW = (N_ZNACAJKI > 1) ? $clog2(N_ZNACAJKI) : 1;
    localparam int CW = (SMIRIVANJE > 1) ? $clog2(SMIRIVANJE) : 1;
    localparam logic [IW-1:0] ZADNJI_IDX = IW'(N_ZNACAJKI - 1);
    localparam logic [CW-1:0] ZADNJI_CNT = CW'(SMIRIVANJE - 1);

    typedef enum logic [1:0] {
        ST_PUNJENJE,
        ST_ODBACIVANJE,
        ST_SMIRIVANJE,
        ST_IZLAZ
    } stanje_t;

    stanje_t        stanje_q, stanje_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           greska_q, greska_d;
    logic           prihvat, upis, hvat;
    logic [15:0]    uzorak_q [N_ZNACAJKI];

    always_comb begin
        stanje_d   = stanje_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        greska_d   = greska_q;
        upis       = 1'b0;
        hvat       = 1'b0;
        // ready is a pure state decode so it never combinationally follows valid
        ulaz_ready = (stanje_q == ST_PUNJENJE) || (stanje_q == ST_ODBACIVANJE);
        prihvat    = ulaz_valid && ulaz_ready;
        rez_valid  = (stanje_q == ST_IZLAZ);
        case (stanje_q)
            ST_PUNJENJE: if (prihvat) begin
                upis = 1'b1;
                if (ulaz_zadnji) begin
                    idx_d = '0;
                    if (idx_q == ZADNJI_IDX) begin
                        stanje_d = ST_SMIRIVANJE;
                        cnt_d    = '0;
                    end else begin
                        greska_d = 1'b1;
                    end
                end else if (idx_q == ZADNJI_IDX) begin
                    greska_d = 1'b1;
                    idx_d    = '0;
                    stanje_d = ST_ODBACIVANJE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_ODBACIVANJE: if (prihvat && ulaz_zadnji) begin
                stanje_d = ST_PUNJENJE;
                idx_d    = '0;
            end
            ST_SMIRIVANJE: if (cnt_q == ZADNJI_CNT) begin
                hvat     = 1'b1;
                cnt_d    = '0;
                stanje_d = ST_IZLAZ;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_IZLAZ: if (rez_ready) stanje_d = ST_PUNJENJE;
            default: stanje_d = ST_PUNJENJE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stanje_q    <= ST_PUNJENJE;
            idx_q       <= '0;
            cnt_q       <= '0;
            greska_q    <= 1'b0;
            rez_izlaz_1 <= '0;
            rez_izlaz_2 <= '0;
            rez_ind_1   <= 1'b0;
            rez_ind_2   <= 1'b0;
        end else begin
            stanje_q <= stanje_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            greska_q <= greska_d;
            if (hvat) begin
                rez_izlaz_1 <= mreza_izlaz_1;
                rez_izlaz_2 <= mreza_izlaz_2;
                rez_ind_1   <= mreza_ind_1;
                rez_ind_2   <= mreza_ind_2;
            end
        end
    end

    // One register slice per feature, written only when the index selects it
    for (genvar g = 0; g < N_ZNACAJKI; g++) begin : g_slice
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                uzorak_q[g] <= '0;
            else if (upis && idx_q == IW'(g))
                uzorak_q[g] <= ulaz_podatak;
        end
        assign uzorak[16*g +: 16] = uzorak_q[g];
    end

    assign greska = greska_q;

`ifdef UPRAVLJAC_BROJAC_EN
    logic [15:0] broj_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            broj_q <= '0;
        else if (stanje_q == ST_IZLAZ && rez_ready)
            broj_q <= broj_q + 16'd1;
    end
    assign broj_uzoraka = broj_q;
`else
    assign broj_uzoraka = '0;
`endif
endmodule

// File: tb/tb_upravljac_mreze.sv
// Directed bench for upravljac_mreze: load, settle/capture, stall, framing errors, async reset, counter wrap.
module tb_upravljac_mreze;
`ifdef UPRAVLJAC_BROJAC_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         ulaz_valid, ulaz_ready, ulaz_zadnji;
    logic [15:0]  ulaz_podatak;
    logic [959:0] uzorak;
    logic [15:0]  mreza_izlaz_1, mreza_izlaz_2;
    logic         mreza_ind_1, mreza_ind_2;
    logic         rez_valid, rez_ready;
    logic [15:0]  rez_izlaz_1, rez_izlaz_2;
    logic         rez_ind_1, rez_ind_2;
    logic         greska;
    logic [15:0]  broj_uzoraka;

    logic [959:0] exp_uz;
    logic [15:0]  exp_broj;
    int total = 0;
    int bad   = 0;

    upravljac_mreze #(.N_ZNACAJKI(60), .SMIRIVANJE(4)) dut (
        .clk(clk), .rst(rst),
        .ulaz_valid(ulaz_valid), .ulaz_ready(ulaz_ready),
        .ulaz_podatak(ulaz_podatak), .ulaz_zadnji(ulaz_zadnji),
        .uzorak(uzorak),
        .mreza_izlaz_1(mreza_izlaz_1), .mreza_izlaz_2(mreza_izlaz_2),
        .mreza_ind_1(mreza_ind_1), .mreza_ind_2(mreza_ind_2),
        .rez_valid(rez_valid), .rez_ready(rez_ready),
        .rez_izlaz_1(rez_izlaz_1), .rez_izlaz_2(rez_izlaz_2),
        .rez_ind_1(rez_ind_1), .rez_ind_2(rez_ind_2),
        .greska(greska), .broj_uzoraka(broj_uzoraka)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [959:0] obs, input logic [959:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n words base+k, ulaz_zadnji on word last; words past 59 are expected to be dropped
    task automatic send(input int base, input int n, input int last);
        for (int k = 0; k < n; k++) begin
            ulaz_valid   = 1'b1;
            ulaz_podatak = 16'(base + k);
            ulaz_zadnji  = (k == last);
            check("ready_while_loading", ulaz_ready, 1'b1);
            tick();
            if (k < 60) exp_uz[16*k +: 16] = 16'(base + k);
        end
        ulaz_valid  = 1'b0;
        ulaz_zadnji = 1'b0;
    endtask

    // Called right after the last-word edge; the real stub values appear only one cycle before capture
    task automatic settle_and_capture(input logic [15:0] s1, input logic [15:0] s2,
                                      input logic i1, input logic i2);
        mreza_izlaz_1 = 16'h1111; mreza_izlaz_2 = 16'h2222;
        mreza_ind_1 = ~i1; mreza_ind_2 = ~i2;
        check("ready_low_after_last", ulaz_ready, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            check("no_valid_during_settle", rez_valid, 1'b0);
            tick();
        end
        check("no_valid_settle_end", rez_valid, 1'b0);
        mreza_izlaz_1 = s1; mreza_izlaz_2 = s2;
        mreza_ind_1 = i1; mreza_ind_2 = i2;
        tick();
        check("rez_valid_at_capture", rez_valid, 1'b1);
        check("rez_izlaz_1", rez_izlaz_1, s1);
        check("rez_izlaz_2", rez_izlaz_2, s2);
        check("rez_ind_1", rez_ind_1, i1);
        check("rez_ind_2", rez_ind_2, i2);
        check("uzorak_after_sample", uzorak, exp_uz);
        mreza_izlaz_1 = 16'h0000; mreza_izlaz_2 = 16'h0000;
        mreza_ind_1 = 1'b0; mreza_ind_2 = 1'b0;
    endtask

    task automatic handshake(input logic [15:0] held1);
        rez_ready = 1'b1;
        tick();
        rez_ready = 1'b0;
        if (CNT_EN) exp_broj = exp_broj + 16'd1;
        check("rez_valid_drop", rez_valid, 1'b0);
        check("ready_after_hs", ulaz_ready, 1'b1);
        check("broj_uzoraka", broj_uzoraka, exp_broj);
        check("rez_hold_after_hs", rez_izlaz_1, held1);
    endtask

    task automatic idle_no_result(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("no_result", rez_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; ulaz_valid = 1'b0; ulaz_podatak = '0; ulaz_zadnji = 1'b0;
        rez_ready = 1'b0; mreza_izlaz_1 = '0; mreza_izlaz_2 = '0;
        mreza_ind_1 = 1'b0; mreza_ind_2 = 1'b0;
        exp_uz = '0; exp_broj = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_ready", ulaz_ready, 1'b1);
        check("rst_valid", rez_valid, 1'b0);
        check("rst_uzorak", uzorak, '0);
        check("rst_izlaz_1", rez_izlaz_1, 16'h0);
        check("rst_greska", greska, 1'b0);
        check("rst_broj", broj_uzoraka, 16'h0);

        // Good sample k, then a 10-cycle stall with valid held against ready=0
        send(0, 60, 59);
        settle_and_capture(16'h8001, 16'h0002, 1'b1, 1'b0);
        check("greska_clean", greska, 1'b0);
        ulaz_valid = 1'b1; ulaz_podatak = 16'hDEAD; ulaz_zadnji = 1'b1;
        mreza_izlaz_1 = 16'h5555; mreza_ind_1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", rez_valid, 1'b1);
            check("stall_ready", ulaz_ready, 1'b0);
            check("stall_izlaz_1", rez_izlaz_1, 16'h8001);
            check("stall_ind_1", rez_ind_1, 1'b1);
            check("stall_uzorak", uzorak, exp_uz);
        end
        ulaz_valid = 1'b0; ulaz_zadnji = 1'b0;
        handshake(16'h8001);

        // Early ulaz_zadnji on word 10, then a clean sample
        send(100, 11, 10);
        check("early_greska", greska, 1'b1);
        check("early_ready", ulaz_ready, 1'b1);
        check("early_uzorak", uzorak, exp_uz);
        idle_no_result(6);
        send(200, 60, 59);
        settle_and_capture(16'h1234, 16'hFEDC, 1'b0, 1'b1);
        handshake(16'h1234);

        // 65 words: 60..64 dropped, then next sample starts at index 0
        send(300, 65, 64);
        check("overrun_greska", greska, 1'b1);
        check("overrun_uzorak", uzorak, exp_uz);
        check("overrun_ready", ulaz_ready, 1'b1);
        idle_no_result(6);
        send(400, 60, 59);
        settle_and_capture(16'h0F0F, 16'h7001, 1'b1, 1'b1);
        handshake(16'h0F0F);

        // Async reset mid-settle, away from any clock edge
        send(500, 60, 59);
        tick(); tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_ready", ulaz_ready, 1'b1);
        check("arst_valid", rez_valid, 1'b0);
        check("arst_uzorak", uzorak, '0);
        check("arst_izlaz_1", rez_izlaz_1, 16'h0);
        check("arst_izlaz_2", rez_izlaz_2, 16'h0);
        check("arst_ind_1", rez_ind_1, 1'b0);
        check("arst_greska", greska, 1'b0);
        check("arst_broj", broj_uzoraka, 16'h0);
        rst = 1'b0;
        exp_uz = '0; exp_broj = '0;
        tick();
        idle_no_result(8);

        // Counter wrap from 0xFFFF
`ifdef UPRAVLJAC_BROJAC_EN
        force dut.broj_q = 16'hFFFF;
        #1;
        release dut.broj_q;
        exp_broj = 16'hFFFF;
        check("broj_preload", broj_uzoraka, 16'hFFFF);
`endif
        tick();
        send(600, 60, 59);
        settle_and_capture(16'hA5A5, 16'h0001, 1'b0, 1'b0);
        handshake(16'hA5A5);
        check("broj_wrap", broj_uzoraka, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
